aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter: NROUNDS, 10, number of cipher rounds; legal range 2..14.
REQ-002 int_osc  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset: 0 resets on the next rising edge of int_osc.
REQ-004 start  input  1  request to encrypt the block/key currently on the datapath inputs.
REQ-005 load_en  output  1  capture plaintext XOR cipher key into the state register.
REQ-006 state_en  output  1  capture the round datapath output into the state register.
REQ-007 mix_bypass  output  1  route shiftrows output around mixcolumns to addroundkey.
REQ-008 key_en  output  1  advance the key-schedule register by one round key.
REQ-009 rcon  output  8  round constant for the current key-expansion step.
REQ-010 round  output  4  current round index, 0..NROUNDS.
REQ-011 busy  output  1  high from start acceptance until done.
REQ-012 done  output  1  one-cycle pulse; the state register holds the ciphertext.

Function
REQ-013 States: IDLE, INIT, ROUND, FINAL, DONE.
REQ-014 IDLE: busy=0. start=1 -> INIT; start=0 -> stay in IDLE.
REQ-015 INIT, one cycle: load_en=1, round=0, busy=1; then -> ROUND with round=1.
REQ-016 ROUND: state_en=1, key_en=1, mix_bypass=0; round increments each cycle; when round=NROUNDS-1 -> FINAL.
REQ-017 FINAL, one cycle: state_en=1, key_en=1, mix_bypass=1, round=NROUNDS; then -> DONE.
REQ-018 DONE, one cycle: done=1, busy=0, all enables 0; then -> IDLE.
REQ-019 Latency: done is high exactly NROUNDS+2 cycles after the edge that samples start=1 in IDLE.
REQ-020 start is ignored outside IDLE; it is neither queued nor able to restart a block.
REQ-021 start=1 during DONE is ignored; a new start is accepted one cycle later in IDLE.
REQ-022 rcon = 0x00 in IDLE, INIT and DONE.
REQ-023 rcon = 0x01 in round 1; each later round applies GF(2^8) xtime to the previous value: shift left, XOR 0x1B on carry-out.
REQ-024 rcon sequence for rounds 1..10: 01 02 04 08 10 20 40 80 1B 36.
REQ-025 load_en, state_en and done are mutually exclusive in every cycle.

Reset
REQ-026 reset=0 at any edge: state -> IDLE, round=0, rcon=0x00, all other outputs 0.
REQ-027 Reset during INIT, ROUND or FINAL abandons the block with no done pulse; reset has priority over start.
REQ-028 A start on the first edge after reset deasserts is accepted normally.

Configuration
REQ-029 Macro AES_KEYWAIT_EN defined: a KEY state precedes every ROUND and FINAL cycle.
REQ-030 In KEY: key_en=1, state_en=0, and rcon is valid one cycle early.
REQ-031 In the ROUND/FINAL cycle that follows KEY: key_en=0.
REQ-032 With AES_KEYWAIT_EN defined, latency is 2*NROUNDS+2.
REQ-033 AES_KEYWAIT_EN undefined: KEY state is absent and REQ-019 applies.

Structure
REQ-034 Package aes_pkg: state enum (IDLE, INIT, KEY, ROUND, FINAL, DONE), RCON_INIT=8'h01, RCON_POLY=8'h1B, constant NROUNDS_128=10.
REQ-035 Sub-module aes_rcon_gen: holds and advances rcon (clear, step inputs; 8-bit output), instantiated once.
REQ-036 Outputs are decoded from registered state; no combinational path from start to any output.

Verification
REQ-037 reset=0 for 3 cycles with start=1 -> all outputs 0; state stays IDLE.
REQ-038 Start pulse, NROUNDS=10 -> load_en at cycle 1; state_en at cycles 2..11; mix_bypass only at cycle 11; done only at cycle 12.
REQ-039 Same run -> rcon sampled on cycles 2..11 equals 01 02 04 08 10 20 40 80 1B 36.
REQ-040 Controller with shiftrows/subbytes/mixcolumns/addroundkey datapath; key 2B7E151628AED2A6ABF7158809CF4F3C; plaintext 3243F6A8885A308D313198A2E0370734 -> ciphertext 3925841D02DC09FBDC118597196A0B32 when done is high.
REQ-041 start held high for 20 cycles -> exactly one done pulse in the first 13 cycles; second block accepted on the cycle after DONE.
REQ-042 reset=0 at round 5 -> IDLE next edge; no done pulse; a subsequent start completes with the correct ciphertext.
REQ-043 AES_KEYWAIT_EN defined, NROUNDS=10 -> done at cycle 22; key_en and state_en never high in the same cycle.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round controller.
// Optional build macro AES_KEYWAIT_EN (see aes_round_ctrl) adds the KEY state.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        KEY,
        ROUND,
        FINAL,
        DONE
    } aes_state_e;

    localparam logic [7:0] RCON_INIT   = 8'h01;
    localparam logic [7:0] RCON_POLY   = 8'h1B;
    localparam int         NROUNDS_128 = 10;

    // GF(2^8) multiply by x, reduced by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: clears to 0x00, first step loads 0x01, later steps apply xtime.
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic       clk_i,
    input  logic       clear_i,
    input  logic       step_i,
    output logic [7:0] rcon_o
);

    logic [7:0] rcon_q, rcon_d;

    always_comb begin
        rcon_d = rcon_q;
        if (clear_i) begin
            rcon_d = 8'h00;
        end else if (step_i) begin
            rcon_d = (rcon_q == 8'h00) ? RCON_INIT : xtime(rcon_q);
        end
    end

    // NOTE: no reset branch here; the parent asserts clear_i while reset is low.
    always_ff @(posedge clk_i) begin
        rcon_q <= rcon_d;
    end

    assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: drives load/state/key enables, round index and rcon.
// Define AES_KEYWAIT_EN to insert a KEY cycle before every ROUND and FINAL cycle.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NROUNDS = NROUNDS_128
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic       start,
    output logic       load_en,
    output logic       state_en,
    output logic       mix_bypass,
    output logic       key_en,
    output logic [7:0] rcon,
    output logic [3:0] round,
    output logic       busy,
    output logic       done
);

`ifdef AES_KEYWAIT_EN
    localparam logic KEY_WITH_ROUND = 1'b0;
`else
    localparam logic KEY_WITH_ROUND = 1'b1;
`endif

    aes_state_e state_q, state_d;
    logic [3:0] round_q, round_d;
    logic       rcon_clear, rcon_step;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge int_osc) begin
        if (!reset) begin
            state_q <= IDLE;
            round_q <= 4'd0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    // NOTE: defaults first so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        unique case (state_q)
            IDLE: begin
                round_d = 4'd0;
                if (start) state_d = INIT;
            end
            INIT: begin
                round_d = 4'd1;
`ifdef AES_KEYWAIT_EN
                state_d = KEY;
`else
                state_d = ROUND;
`endif
            end
`ifdef AES_KEYWAIT_EN
            KEY:   state_d = (round_q == 4'(NROUNDS)) ? FINAL : ROUND;
            ROUND: begin
                state_d = KEY;
                round_d = round_q + 4'd1;
            end
`else
            ROUND: begin
                round_d = round_q + 4'd1;
                if (round_q == 4'(NROUNDS - 1)) state_d = FINAL;
            end
`endif
            FINAL: state_d = DONE;
            DONE: begin
                state_d = IDLE;
                round_d = 4'd0;
            end
            default: begin
                state_d = IDLE;
                round_d = 4'd0;
            end
        endcase
    end

    // rcon advances on entry to the cycle that consumes it (KEY when key-wait is built in).
    always_comb begin
        rcon_clear = !reset || (state_d == IDLE) || (state_d == INIT) || (state_d == DONE);
`ifdef AES_KEYWAIT_EN
        rcon_step  = (state_d == KEY);
`else
        rcon_step  = (state_d == ROUND) || (state_d == FINAL);
`endif
    end

    aes_rcon_gen u_rcon_gen (
        .clk_i   (int_osc),
        .clear_i (rcon_clear),
        .step_i  (rcon_step),
        .rcon_o  (rcon)
    );

    always_comb begin
        load_en    = 1'b0;
        state_en   = 1'b0;
        mix_bypass = 1'b0;
        key_en     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        round      = round_q;
        unique case (state_q)
            INIT: begin
                load_en = 1'b1;
                busy    = 1'b1;
            end
            KEY: begin
                key_en = 1'b1;
                busy   = 1'b1;
            end
            ROUND: begin
                state_en = 1'b1;
                key_en   = KEY_WITH_ROUND;
                busy     = 1'b1;
            end
            FINAL: begin
                state_en   = 1'b1;
                key_en     = KEY_WITH_ROUND;
                mix_bypass = 1'b1;
                busy       = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench: cycle-phase reference model plus a behavioural AES-128 datapath.
module tb_aes_round_ctrl;

    localparam int N = 10;
`ifdef AES_KEYWAIT_EN
    localparam bit KW  = 1'b1;
    localparam int LAT = 2 * N + 2;
`else
    localparam bit KW  = 1'b0;
    localparam int LAT = N + 2;
`endif

    localparam logic [127:0] KEY_IN = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] PT_IN  = 128'h3243F6A8885A308D313198A2E0370734;
    localparam logic [127:0] CT_EXP = 128'h3925841D02DC09FBDC118597196A0B32;

    logic       int_osc;
    logic       reset;
    logic       start;
    logic       load_en, state_en, mix_bypass, key_en, busy, done;
    logic [7:0] rcon;
    logic [3:0] round;

    int n_checks = 0;
    int n_errors = 0;
    int k        = 0;   // cycles since start acceptance, 0 when idle
    int dones    = 0;

    logic [7:0] rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    aes_round_ctrl #(.NROUNDS(N)) dut (
        .int_osc    (int_osc),
        .reset      (reset),
        .start      (start),
        .load_en    (load_en),
        .state_en   (state_en),
        .mix_bypass (mix_bypass),
        .key_en     (key_en),
        .rcon       (rcon),
        .round      (round),
        .busy       (busy),
        .done       (done)
    );

    initial int_osc = 1'b0;
    always #5 int_osc = ~int_osc;

    // ---------------- AES arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15 - n -: 8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] t;
        logic [127:0] m;
        logic [7:0]   a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) begin
            t[127 - 8 * i -: 8] = sbox(st[127 - 8 * (4 * (((i / 4) + (i % 4)) % 4) + (i % 4)) -: 8]);
        end
        m = t;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[127 - 32 * c -: 8];
                a1 = t[119 - 32 * c -: 8];
                a2 = t[111 - 32 * c -: 8];
                a3 = t[103 - 32 * c -: 8];
                m[127 - 32 * c -: 8] = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
                m[119 - 32 * c -: 8] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
                m[111 - 32 * c -: 8] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
                m[103 - 32 * c -: 8] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
            end
        end
        return m ^ rk;
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] kk, input logic [7:0] rc);
        logic [31:0] w0 = kk[127:96], w1 = kk[95:64], w2 = kk[63:32], w3 = kk[31:0];
        logic [31:0] tmp;
        tmp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ tmp;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Datapath steered only by the controller outputs.
    logic [127:0] dp_state, dp_key;
    always @(posedge int_osc) begin
        if (load_en) begin
            dp_state <= PT_IN ^ KEY_IN;
            dp_key   <= KEY_IN;
        end else begin
            if (state_en)
                dp_state <= aes_round(dp_state, key_en ? key_next(dp_key, rcon) : dp_key, mix_bypass);
            if (key_en)
                dp_key <= key_next(dp_key, rcon);
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       load_en, state_en, mix, key_en, busy, done, chk_round;
        logic [7:0] rcon;
        logic [3:0] round;
    } exp_t;

    function automatic logic [7:0] rc_of(input int r);
        logic [7:0] v = 8'h01;
        for (int i = 1; i < r; i++) v = gmul(v, 8'h02);
        return v;
    endfunction

    function automatic exp_t exp_at(input int kk);
        exp_t e = '0;
        int   r;
        e.chk_round = 1'b1;
        if (kk == 1) begin
            e.load_en = 1'b1;
            e.busy    = 1'b1;
        end else if (kk == LAT) begin
            e.done      = 1'b1;
            e.chk_round = 1'b0;
        end else if (kk >= 2) begin
            r       = KW ? kk / 2 : kk - 1;
            e.busy  = 1'b1;
            e.round = 4'(r);
            e.rcon  = rc_of(r);
            if (KW && (kk % 2 == 0)) begin
                e.key_en = 1'b1;
            end else begin
                e.state_en = 1'b1;
                e.key_en   = !KW;
                e.mix      = (r == N);
            end
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_outputs();
        exp_t e = exp_at(k);
        check($sformatf("load_en k=%0d", k),    load_en,    e.load_en);
        check($sformatf("state_en k=%0d", k),   state_en,   e.state_en);
        check($sformatf("mix_bypass k=%0d", k), mix_bypass, e.mix);
        check($sformatf("key_en k=%0d", k),     key_en,     e.key_en);
        check($sformatf("busy k=%0d", k),       busy,       e.busy);
        check($sformatf("done k=%0d", k),       done,       e.done);
        check($sformatf("rcon k=%0d", k),       rcon,       e.rcon);
        if (e.chk_round) check($sformatf("round k=%0d", k), round, e.round);
        check($sformatf("exclusive k=%0d", k), ($countones({load_en, state_en, done}) <= 1), 1'b1);
        if (done === 1'b1) check("ciphertext", dp_state, CT_EXP);
    endtask

    task automatic tick(input logic rst_v, input logic st_v);
        reset = rst_v;
        start = st_v;
        @(posedge int_osc);
        if (!rst_v)        k = 0;
        else if (k == 0)   k = st_v ? 1 : 0;
        else if (k == LAT) k = 0;
        else               k = k + 1;
        #1;
        if (done === 1'b1) dones++;
        check_outputs();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        reset = 1'b0;
        start = 1'b0;

        // Reset held low with start asserted.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);

        // Single block with a one-cycle start pulse.
        d0 = dones;
        tick(1'b1, 1'b1);
        for (int c = 2; c <= LAT; c++) begin
            tick(1'b1, 1'b0);
            if (!KW && c <= 11) check($sformatf("rcon table cycle %0d", c), rcon, rc_tab[c - 2]);
        end
        check("done at latency", done, 1'b1);
        tick(1'b1, 1'b0);
        check("single block done count", dones - d0, 1);

        // Start held high: one done per block, next block accepted right after DONE.
        d0 = dones;
        for (int i = 1; i <= LAT + 8; i++) begin
            tick(1'b1, 1'b1);
            if (i == LAT + 1) check("held start done count", dones - d0, 1);
            if (i == LAT + 2) check("held start re-accept", load_en, 1'b1);
        end
        for (int i = 0; i < LAT + 2; i++) tick(1'b1, 1'b0);

        // Abort at round 5, then a clean block.
        tick(1'b1, 1'b1);
        for (int g = 0; g < 3 * LAT && !(round === 4'd5 && state_en === 1'b1); g++) tick(1'b1, 1'b0);
        check("round before abort", round, 4'd5);
        d0 = dones;
        tick(1'b0, 1'b1);
        check("busy after abort", busy, 1'b0);
        for (int i = 0; i < LAT + 2; i++) tick(1'b1, 1'b0);
        check("no done after abort", dones - d0, 0);
        tick(1'b1, 1'b1);
        for (int i = 0; i < LAT; i++) tick(1'b1, 1'b0);
        check("done after abort recovery", dones - d0, 1);

        // Randomized start and reset traffic.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
